// File: rtl/blink_sequencer_pkg.sv
// blink_pkg: shared state type, index-width helper and repeat constant for blink_sequencer
package blink_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam logic [7:0] REPEAT_INFINITE = 8'd0;
    function automatic int idx_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction
endpackage

// File: rtl/blink_sequencer_if.sv
// blink_sequencer_if: start/stop/config and status bundle between scheduler and sequencer
interface blink_sequencer_if #(
    parameter int PRESCALE_W = 24,
    parameter int STEPS = 4,
    parameter int OUT_W = 3
);
    import blink_pkg::*;
    localparam int IW = idx_w(STEPS);
    logic start;
    logic stop;
    logic [PRESCALE_W-1:0] period;
    logic [7:0] repeat_count;
    logic [STEPS*OUT_W-1:0] pattern;
    logic busy;
    logic done;
    logic [IW-1:0] step_idx;
    logic [OUT_W-1:0] out;
    modport master (output start, stop, period, repeat_count, pattern, input busy, done, step_idx, out);
    modport slave (input start, stop, period, repeat_count, pattern, output busy, done, step_idx, out);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts enabled cycles and pulses tick on the last cycle of each period
module tick_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input logic clk,
    input logic rst_n,
    input logic clear,
    input logic en,
    input logic [PRESCALE_W-1:0] period,
    output logic tick
);
    logic [PRESCALE_W-1:0] r_cnt;
    assign tick = en && (r_cnt == period - 1'b1);
    always_ff @(posedge clk) begin
        if (!rst_n || clear) r_cnt <= '0;
        else if (en) r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: steps a latched pattern table onto pins at a programmed rate for N passes
module blink_sequencer import blink_pkg::*; #(
    parameter int PRESCALE_W = 24,
    parameter int STEPS = 4,
    parameter int OUT_W = 3
) (
    input logic clk,
    input logic rst_n,
    blink_sequencer_if.slave bus
);
    localparam int IW = idx_w(STEPS);
    state_t r_state;
    logic [PRESCALE_W-1:0] r_period;
    logic [7:0] r_repeat;
    logic [7:0] r_pass;
    logic [STEPS*OUT_W-1:0] r_pattern;
    logic [IW-1:0] r_idx;
    logic [OUT_W-1:0] r_out;
    logic r_busy;
    logic r_done;
    logic w_tick;
    logic w_last_step;
    logic w_last_pass;
    logic [IW-1:0] w_next_idx;
    assign w_last_step = r_idx == IW'(STEPS - 1);
    assign w_last_pass = (r_repeat != REPEAT_INFINITE) && (r_pass == r_repeat - 8'd1);
    assign w_next_idx = w_last_step ? '0 : r_idx + 1'b1;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.step_idx = r_idx;
    assign bus.out = r_out;
    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk(clk),
        .rst_n(rst_n),
        .clear(r_state != RUN),
        .en(r_state == RUN),
        .period(r_period),
        .tick(w_tick)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_period <= '0;
            r_repeat <= '0;
            r_pass <= '0;
            r_pattern <= '0;
            r_idx <= '0;
            r_out <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_period <= (bus.period == '0) ? PRESCALE_W'(1) : bus.period;
                    r_repeat <= bus.repeat_count;
                    r_pattern <= bus.pattern;
                    r_pass <= '0;
                    r_idx <= '0;
                    r_out <= bus.pattern[OUT_W-1:0];
                    r_busy <= 1'b1;
                    r_state <= RUN;
                end
                RUN: if (bus.stop) begin
                    r_state <= IDLE;
                    r_busy <= 1'b0;
                    r_out <= '0;
                    r_idx <= '0;
                end else if (w_tick) begin
                    if (w_last_step && w_last_pass) begin
                        r_state <= FINISH;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                        r_out <= '0;
                        r_idx <= '0;
                    end else begin
                        r_idx <= w_next_idx;
                        r_out <= r_pattern[int'(w_next_idx)*OUT_W +: OUT_W];
                        if (w_last_step && r_repeat != REPEAT_INFINITE) r_pass <= r_pass + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: randomized scoreboard bench against an elapsed-time reference model
module tb_blink_sequencer;
    import blink_pkg::*;
    localparam int PW = 24;
    localparam int S = 4;
    localparam int OW = 3;
    localparam int IW = idx_w(S);
    localparam int PAT_W = S * OW;
    localparam logic [PAT_W-1:0] PAT = 12'b100_011_010_001;
    typedef struct packed {
        logic busy;
        logic done;
        logic [IW-1:0] idx;
        logic [OW-1:0] out;
    } snap_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    blink_sequencer_if #(.PRESCALE_W(PW), .STEPS(S), .OUT_W(OW)) bus();
    blink_sequencer #(.PRESCALE_W(PW), .STEPS(S), .OUT_W(OW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int busy_seen = 0;
    int m_state = 0;
    longint m_k;
    longint m_total;
    int m_p;
    logic [PAT_W-1:0] m_pat;
    // Reference: position in the run is elapsed RUN cycles; entry = (elapsed / period) mod STEPS
    initial forever begin
        snap_t e;
        int idx;
        @(posedge clk);
        e = '0;
        if (!rst_n) m_state = 0;
        else if (m_state == 0) begin
            if (bus.start) begin
                m_p = (bus.period == 0) ? 1 : int'(bus.period);
                m_total = longint'(bus.repeat_count) * S * m_p;
                m_pat = bus.pattern;
                m_k = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (bus.stop) m_state = 0;
            else begin
                m_k++;
                if (m_total != 0 && m_k == m_total) m_state = 2;
            end
        end else m_state = 0;
        if (m_state == 1) begin
            idx = int'((m_k / m_p) % S);
            e.busy = 1'b1;
            e.idx = IW'(idx);
            e.out = m_pat[idx*OW +: OW];
        end
        e.done = (m_state == 2);
        exp_q.push_back(e);
    end
    initial forever begin
        snap_t e;
        snap_t a;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.busy, bus.done, bus.step_idx, bus.out};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got busy=%b done=%b idx=%0d out=%b want busy=%b done=%b idx=%0d out=%b",
                         $time, a.busy, a.done, a.idx, a.out, e.busy, e.done, e.idx, e.out);
            end
            done_seen += int'(bus.done);
            busy_seen += int'(bus.busy);
        end
    end
    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic launch(input logic [PW-1:0] p, input logic [7:0] r, input logic [PAT_W-1:0] pat);
        bus.period = p;
        bus.repeat_count = r;
        bus.pattern = pat;
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            if (!bus.busy && !bus.done) break;
            cyc(1);
        end
        check("wait_idle_timeout", longint'(bus.busy | bus.done), 0);
    endtask
    initial begin
        int d0;
        int b0;
        bus.start = 1'b1;
        bus.stop = 1'b0;
        bus.period = PW'(2);
        bus.repeat_count = 8'd1;
        bus.pattern = PAT;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        check("start_after_reset_busy", longint'(bus.busy), 1);
        wait_idle();
        d0 = done_seen;
        b0 = busy_seen;
        launch(PW'(2), 8'd1, PAT);
        wait_idle();
        check("single_pass_done", done_seen - d0, 1);
        check("single_pass_run_cycles", busy_seen - b0, 8);
        d0 = done_seen;
        b0 = busy_seen;
        launch(PW'(0), 8'd3, PAT_W'($urandom));
        wait_idle();
        check("period0_done", done_seen - d0, 1);
        check("period0_run_cycles", busy_seen - b0, 12);
        d0 = done_seen;
        launch(PW'(2), 8'd1, PAT);
        cyc(7);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        check("stop_prio_busy", longint'(bus.busy), 0);
        check("stop_prio_out", longint'(bus.out), 0);
        cyc(3);
        check("stop_prio_no_done", done_seen - d0, 0);
        d0 = done_seen;
        launch(PW'(1), 8'd0, PAT);
        cyc(1000);
        check("infinite_no_done", done_seen - d0, 0);
        check("infinite_busy", longint'(bus.busy), 1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        check("infinite_stop_busy", longint'(bus.busy), 0);
        d0 = done_seen;
        b0 = busy_seen;
        launch(PW'(3), 8'd2, PAT);
        cyc(4);
        bus.start = 1'b1;
        bus.pattern = ~PAT;
        bus.period = PW'(7);
        bus.repeat_count = 8'd9;
        cyc(2);
        bus.start = 1'b0;
        wait_idle();
        check("ignored_inputs_run_cycles", busy_seen - b0, 24);
        check("ignored_inputs_done", done_seen - d0, 1);
        d0 = done_seen;
        launch(PW'(2), 8'd2, PAT);
        cyc(5);
        rst_n = 1'b0;
        cyc(1);
        check("midrun_reset_busy", longint'(bus.busy), 0);
        check("midrun_reset_out", longint'(bus.out), 0);
        check("midrun_reset_idx", longint'(bus.step_idx), 0);
        rst_n = 1'b1;
        cyc(2);
        check("midrun_reset_no_done", done_seen - d0, 0);
        for (int t = 0; t < 40; t++) begin
            launch(PW'($urandom_range(0, 4)), 8'($urandom_range(0, 3)), PAT_W'($urandom));
            for (int j = $urandom_range(1, 60); j > 0; j--) begin
                bus.stop = ($urandom_range(0, 15) == 0);
                bus.start = ($urandom_range(0, 3) == 0);
                bus.pattern = PAT_W'($urandom);
                bus.period = PW'($urandom_range(0, 4));
                bus.repeat_count = 8'($urandom_range(0, 3));
                rst_n = ($urandom_range(0, 63) != 0);
                cyc(1);
            end
            bus.start = 1'b0;
            bus.stop = 1'b1;
            rst_n = 1'b1;
            cyc(2);
            bus.stop = 1'b0;
            wait_idle();
        end
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
